// File: rtl/label_pkg.sv
// Shared types for the assembler label table, parser and resolver.
package label_pkg;
  localparam int LABEL_CHARS = 8;
  localparam int NAME_W      = LABEL_CHARS * 8;

  typedef logic [NAME_W-1:0] label_name_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEF_SCAN  = 2'd1,
    LOOK_SCAN = 2'd2,
    RESP      = 2'd3
  } label_state_t;
endpackage

// File: rtl/label_match.sv
// One table-entry comparator: hit when the entry is live and its name equals the request.
module label_match
  import label_pkg::*;
(
  input  logic [NAME_W-1:0] entry_name_i,
  input  logic [NAME_W-1:0] req_name_i,
  input  logic              entry_valid_i,
  output logic              match_o
);
  assign match_o = entry_valid_i && (entry_name_i == req_name_i);
endmodule

// File: rtl/label_table.sv
// Assembler symbol table: define/lookup of label names with a linear scan.
// LABEL_TABLE_PARALLEL_EN compares every entry in a single scan cycle.
module label_table
  import label_pkg::*;
#(
  parameter  int MAX_LABELS   = 32,
  parameter  int NUMBER_LINES = 256,
  localparam int PC_W         = $clog2(NUMBER_LINES * 4),
  localparam int CNT_W        = $clog2(MAX_LABELS + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   clear_in,
  input  logic                   define_valid_in,
  input  logic [NAME_W-1:0]      define_name_in,
  input  logic [PC_W-1:0]        define_pc_in,
  output logic                   define_ready_out,
  input  logic                   lookup_valid_in,
  input  logic [NAME_W-1:0]      lookup_name_in,
  output logic                   lookup_ready_out,
  output logic                   def_done_out,
  output logic                   result_valid_out,
  output logic                   result_found_out,
  output logic [PC_W-1:0]        result_pc_out,
  output logic [CNT_W-1:0]       count_out,
  output logic                   full_out,
  output logic                   dup_error_out,
  output logic                   overflow_out
);
  localparam int              ADDR_W  = $clog2(MAX_LABELS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LABELS);

  label_state_t      state_q;
  logic [CNT_W-1:0]  count_q;
  logic [NAME_W-1:0] req_name_q;
  logic [PC_W-1:0]   req_pc_q;
  logic              is_def_q, hit_q;
  logic [ADDR_W-1:0] hit_idx_q;
  logic              def_done_q, result_valid_q, found_q, dup_q, ovf_q;
  logic [PC_W-1:0]   res_pc_q;

  logic [NAME_W-1:0] names_q [MAX_LABELS];
  logic [PC_W-1:0]   pcs_q   [MAX_LABELS];

  logic              scanning_c, scan_done_c, hit_c, we_c;
  logic [ADDR_W-1:0] hit_idx_c;

  assign scanning_c = (state_q == DEF_SCAN) || (state_q == LOOK_SCAN);

`ifdef LABEL_TABLE_PARALLEL_EN
  logic [MAX_LABELS-1:0] match_vec;

  for (genvar g = 0; g < MAX_LABELS; g++) begin : g_match
    label_match u_match (
      .entry_name_i  (names_q[g]),
      .req_name_i    (req_name_q),
      .entry_valid_i (CNT_W'(g) < count_q),
      .match_o       (match_vec[g])
    );
  end

  // Walk downward so the lowest matching index is the one left standing.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = MAX_LABELS - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit_c     = 1'b1;
        hit_idx_c = ADDR_W'(i);
      end
    end
  end

  assign scan_done_c = 1'b1;
`else
  logic [CNT_W-1:0] idx_q;

  label_match u_match (
    .entry_name_i  (names_q[idx_q[ADDR_W-1:0]]),
    .req_name_i    (req_name_q),
    .entry_valid_i (idx_q < count_q),
    .match_o       (hit_c)
  );

  assign hit_idx_c   = idx_q[ADDR_W-1:0];
  assign scan_done_c = hit_c || (idx_q == count_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                     idx_q <= '0;
    else if (clear_in || !scanning_c)  idx_q <= '0;
    else                               idx_q <= idx_q + CNT_W'(1);
  end
`endif

  // Entry storage carries no reset; only entries below count_q are ever compared.
  assign we_c = (state_q == RESP) && is_def_q && !hit_q && (count_q != MAX_CNT) && !clear_in;

  always_ff @(posedge clk_in) begin
    if (we_c) begin
      names_q[count_q[ADDR_W-1:0]] <= req_name_q;
      pcs_q[count_q[ADDR_W-1:0]]   <= req_pc_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      count_q        <= '0;
      req_name_q     <= '0;
      req_pc_q       <= '0;
      is_def_q       <= 1'b0;
      hit_q          <= 1'b0;
      hit_idx_q      <= '0;
      def_done_q     <= 1'b0;
      result_valid_q <= 1'b0;
      found_q        <= 1'b0;
      res_pc_q       <= '0;
      dup_q          <= 1'b0;
      ovf_q          <= 1'b0;
    end else if (clear_in) begin
      state_q        <= IDLE;
      count_q        <= '0;
      dup_q          <= 1'b0;
      ovf_q          <= 1'b0;
      def_done_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      def_done_q     <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (define_valid_in) begin
            req_name_q <= define_name_in;
            req_pc_q   <= define_pc_in;
            is_def_q   <= 1'b1;
            state_q    <= DEF_SCAN;
          end else if (lookup_valid_in) begin
            req_name_q <= lookup_name_in;
            is_def_q   <= 1'b0;
            state_q    <= LOOK_SCAN;
          end
        end
        DEF_SCAN, LOOK_SCAN: begin
          if (scan_done_c) begin
            hit_q     <= hit_c;
            hit_idx_q <= hit_idx_c;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (is_def_q) begin
            def_done_q <= 1'b1;
            if (hit_q)                  dup_q   <= 1'b1;
            else if (count_q != MAX_CNT) count_q <= count_q + CNT_W'(1);
            else                        ovf_q   <= 1'b1;
          end else begin
            result_valid_q <= 1'b1;
            found_q        <= hit_q;
            res_pc_q       <= hit_q ? pcs_q[hit_idx_q] : '0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign define_ready_out = (state_q == IDLE);
  assign lookup_ready_out = (state_q == IDLE);
  assign def_done_out     = def_done_q;
  assign result_valid_out = result_valid_q;
  assign result_found_out = found_q;
  assign result_pc_out    = res_pc_q;
  assign count_out        = count_q;
  assign full_out         = (count_q == MAX_CNT);
  assign dup_error_out    = dup_q;
  assign overflow_out     = ovf_q;
endmodule
